// File: rtl/glitcbus_master.sv
// GLITCBUS initiator: frames one 16-bit address / 32-bit data transfer per
// request onto the shared byte bus, with one select line per GLITC.
module glitcbus_master #(
    parameter int NUM_GLITC = 4,
    parameter int READ_WAIT = 2,
    localparam int IW = (NUM_GLITC > 1) ? $clog2(NUM_GLITC) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IW-1:0]        user_glitc_i,
    input  logic [15:0]          user_addr_i,
    input  logic [31:0]          user_dat_i,
    input  logic                 user_wr_i,
    input  logic                 user_rd_i,
    output logic [31:0]          user_dat_o,
    output logic                 user_ack_o,
    output logic                 user_busy_o,
    output logic [NUM_GLITC-1:0] GSEL_B,
    output logic                 GRDWR_B,
    output logic [7:0]           gad_o,
    output logic                 gad_oe_o,
    input  logic [7:0]           gad_i
);

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, WDATA, TURN, RDATA, DONE
    } state_t;

    state_t state, state_n, vis;

    logic [IW-1:0]        idx_q;
    logic [15:0]          addr_q;
    logic [31:0]          wdat_q;
    logic                 rd_q;
    logic [1:0]           byte_q, byte_n;
    logic [2:0]           turn_q, turn_n;
    logic [23:0]          shreg;
    logic                 req, idx_ok, sel_act, oe_n;
    logic [NUM_GLITC-1:0] sel_n;
    logic [7:0]           gad_n;

    assign req    = user_wr_i | user_rd_i;
    assign idx_ok = 32'(idx_q) < 32'(NUM_GLITC);

    always_comb begin
        state_n = state;
        byte_n  = byte_q;
        turn_n  = turn_q;
        unique case (state)
            IDLE: if (req) state_n = ADDR_HI;
            ADDR_HI: state_n = ADDR_LO;
            ADDR_LO: begin
                byte_n  = 2'd0;
                turn_n  = 3'd0;
                state_n = rd_q ? TURN : WDATA;
            end
            WDATA: begin
                byte_n = byte_q + 2'd1;
                if (byte_q == 2'd3) state_n = DONE;
            end
            TURN: begin
                turn_n = turn_q + 3'd1;
                if (turn_q == 3'(READ_WAIT - 1)) begin
                    byte_n  = 2'd0;
                    state_n = RDATA;
                end
            end
            RDATA: begin
                byte_n = byte_q + 2'd1;
                if (byte_q == 2'd3) state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bus pins are a registered decode of the current state, so every pin
    // lags the FSM by one cycle; capture logic follows that lag via vis.
    always_comb begin
        sel_act = state inside {ADDR_HI, ADDR_LO, WDATA, TURN, RDATA};
        oe_n    = state inside {ADDR_HI, ADDR_LO, WDATA};
        sel_n   = '1;
        for (int i = 0; i < NUM_GLITC; i++) begin
            if (sel_act && 32'(idx_q) == 32'(i)) sel_n[i] = 1'b0;
        end
        gad_n = 8'h00;
        unique case (state)
            ADDR_HI: gad_n = addr_q[15:8];
            ADDR_LO: gad_n = addr_q[7:0];
            WDATA: begin
                unique case (byte_q)
                    2'd0: gad_n = wdat_q[31:24];
                    2'd1: gad_n = wdat_q[23:16];
                    2'd2: gad_n = wdat_q[15:8];
                    2'd3: gad_n = wdat_q[7:0];
                    default: gad_n = 8'h00;
                endcase
            end
            default: gad_n = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            vis         <= IDLE;
            idx_q       <= '0;
            addr_q      <= 16'h0000;
            wdat_q      <= 32'h0000_0000;
            rd_q        <= 1'b0;
            byte_q      <= 2'd0;
            turn_q      <= 3'd0;
            shreg       <= 24'h00_0000;
            user_dat_o  <= 32'h0000_0000;
            user_ack_o  <= 1'b0;
            user_busy_o <= 1'b0;
            GSEL_B      <= '1;
            GRDWR_B     <= 1'b1;
            gad_o       <= 8'h00;
            gad_oe_o    <= 1'b0;
        end else begin
            state  <= state_n;
            vis    <= state;
            byte_q <= byte_n;
            turn_q <= turn_n;
            if (state == IDLE && req) begin
                idx_q  <= user_glitc_i;
                addr_q <= user_addr_i;
                wdat_q <= user_dat_i;
                rd_q   <= ~user_wr_i;
            end
            if (vis == RDATA) shreg <= {shreg[15:0], gad_i};
            // Unselected GLITCs leave GAD floating, so their reads return zero.
            if (vis == RDATA && state == DONE)
                user_dat_o <= idx_ok ? {shreg, gad_i} : 32'h0000_0000;
            user_ack_o  <= (state == DONE);
            user_busy_o <= (state_n != IDLE);
            GSEL_B      <= sel_n;
            GRDWR_B     <= sel_act ? rd_q : 1'b1;
            gad_o       <= gad_n;
            gad_oe_o    <= oe_n;
        end
    end

endmodule

// File: tb/tb_glitcbus_master.sv
// Scoreboard bench for glitcbus_master: two instances (default and
// NUM_GLITC=3/READ_WAIT=5) with behavioural GLITC read slaves.
module tb_glitcbus_master;

    typedef struct {
        bit          rd;
        logic [31:0] dat;
        logic [47:0] bytes;
        int          nb;
        int          selc;
        logic [3:0]  mask;
        int          oec;
        int          oelow;
        int          lat;
        int          req;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]  a_glitc;
    logic [15:0] a_addr;
    logic [31:0] a_datw, a_dato;
    logic        a_wr, a_rd, a_ack, a_busy, a_grdwr, a_oe;
    logic [3:0]  a_gsel;
    logic [7:0]  a_gad, a_gadi;

    logic [1:0]  b_glitc;
    logic [15:0] b_addr;
    logic [31:0] b_datw, b_dato;
    logic        b_wr, b_rd, b_ack, b_busy, b_grdwr, b_oe;
    logic [2:0]  b_gsel;
    logic [7:0]  b_gad, b_gadi;

    logic [7:0] a_rb [4];
    logic [7:0] b_rb [4];
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb, tmp;

    glitcbus_master #(.NUM_GLITC(4), .READ_WAIT(2)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .user_glitc_i(a_glitc), .user_addr_i(a_addr), .user_dat_i(a_datw),
        .user_wr_i(a_wr), .user_rd_i(a_rd), .user_dat_o(a_dato),
        .user_ack_o(a_ack), .user_busy_o(a_busy),
        .GSEL_B(a_gsel), .GRDWR_B(a_grdwr),
        .gad_o(a_gad), .gad_oe_o(a_oe), .gad_i(a_gadi)
    );

    glitcbus_master #(.NUM_GLITC(3), .READ_WAIT(5)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .user_glitc_i(b_glitc), .user_addr_i(b_addr), .user_dat_i(b_datw),
        .user_wr_i(b_wr), .user_rd_i(b_rd), .user_dat_o(b_dato),
        .user_ack_o(b_ack), .user_busy_o(b_busy),
        .GSEL_B(b_gsel), .GRDWR_B(b_grdwr),
        .gad_o(b_gad), .gad_oe_o(b_oe), .gad_i(b_gadi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_w(input logic [3:0] mask,
                                  input logic [15:0] addr,
                                  input logic [31:0] d);
        exp_t e;
        e.rd = 1'b0; e.dat = 32'h0; e.bytes = {addr, d}; e.nb = 6;
        e.selc = 6; e.mask = mask; e.oec = 6; e.oelow = 0; e.lat = 7;
        e.req = 0;
        return e;
    endfunction

    function automatic exp_t mk_r(input logic [3:0] mask,
                                  input logic [15:0] addr,
                                  input logic [31:0] d, input int rw);
        exp_t e;
        e.rd = 1'b1; e.dat = d; e.bytes = {32'h0, addr}; e.nb = 2;
        e.selc = 6 + rw; e.mask = mask; e.oec = 2; e.oelow = 4 + rw;
        e.lat = 7 + rw; e.req = 0;
        return e;
    endfunction

    // Read slaves: bytes appear on the cycles the pins show RDATA.
    int a_k = 0;
    int b_k = 0;
    always @(negedge clk) begin
        if (a_busy) a_k++; else a_k = 0;
        if (a_gsel != 4'hF && a_grdwr && a_k >= 6 && a_k <= 9)
            a_gadi = a_rb[a_k-6];
        else
            a_gadi = 8'hA5;
        if (b_busy) b_k++; else b_k = 0;
        if (b_gsel != 3'h7 && b_grdwr && b_k >= 9 && b_k <= 12)
            b_gadi = b_rb[b_k-9];
        else
            b_gadi = 8'hA5;
    end

    logic [47:0] a_bytes;
    int          a_nb, a_selc, a_oec, a_oelow;
    logic [3:0]  a_mask;
    logic        a_gor, a_gand;
    logic [31:0] a_last;

    task automatic clr_a();
        a_bytes = 48'h0; a_nb = 0; a_selc = 0; a_oec = 0; a_oelow = 0;
        a_mask = 4'h0; a_gor = 1'b0; a_gand = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            clr_a();
            a_last = 32'h0;
        end else begin
            if (a_oe) a_oec++;
            if (a_gsel != 4'hF) begin
                a_selc++;
                a_mask = a_mask | ~a_gsel;
                a_gor  = a_gor | a_grdwr;
                a_gand = a_gand & a_grdwr;
                if (a_oe) begin
                    a_bytes = {a_bytes[39:0], a_gad};
                    a_nb++;
                end else begin
                    a_oelow++;
                end
            end
            if (a_ack) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_ack", 64'(a_ack), 64'(0));
                end else begin
                    ea = qa.pop_front();
                    if (ea.rd) a_last = ea.dat;
                    chk("a_latency", 64'(cyc - ea.req), 64'(ea.lat));
                    chk("a_sel_cycles", 64'(a_selc), 64'(ea.selc));
                    chk("a_sel_mask", 64'(a_mask), 64'(ea.mask));
                    chk("a_gad_bytes", 64'(a_bytes), 64'(ea.bytes));
                    chk("a_gad_count", 64'(a_nb), 64'(ea.nb));
                    chk("a_oe_cycles", 64'(a_oec), 64'(ea.oec));
                    chk("a_oe_low_sel", 64'(a_oelow), 64'(ea.oelow));
                    chk("a_grdwr", 64'({a_gor, a_gand}), 64'({ea.rd, ea.rd}));
                    chk("a_user_dat", 64'(a_dato), 64'(a_last));
                    chk("a_sel_at_ack", 64'(a_gsel), 64'(4'hF));
                    chk("a_busy_at_ack", 64'(a_busy), 64'(0));
                end
                clr_a();
            end
        end
    end

    int         b_selc, b_oec;
    logic [3:0] b_mask;

    always @(negedge clk) begin
        if (rst) begin
            b_selc = 0; b_oec = 0; b_mask = 4'h0;
        end else begin
            if (b_oe) b_oec++;
            if (b_gsel != 3'h7) begin
                b_selc++;
                b_mask = b_mask | {1'b0, ~b_gsel};
            end
            if (b_ack) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_ack", 64'(b_ack), 64'(0));
                end else begin
                    eb = qb.pop_front();
                    chk("b_latency", 64'(cyc - eb.req), 64'(eb.lat));
                    chk("b_sel_cycles", 64'(b_selc), 64'(eb.selc));
                    chk("b_sel_mask", 64'(b_mask), 64'(eb.mask));
                    chk("b_oe_cycles", 64'(b_oec), 64'(eb.oec));
                    chk("b_user_dat", 64'(b_dato), 64'(eb.dat));
                end
                b_selc = 0; b_oec = 0; b_mask = 4'h0;
            end
        end
    end

    task automatic issue_a(input bit now, input bit wr, input bit rd,
                           input logic [1:0] idx, input logic [15:0] addr,
                           input logic [31:0] wd, input exp_t e);
        if (!now) @(negedge clk);
        a_glitc = idx; a_addr = addr; a_datw = wd; a_wr = wr; a_rd = rd;
        e.req = cyc + 1;
        qa.push_back(e);
        @(negedge clk);
        a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic issue_b(input logic [1:0] idx, input logic [15:0] addr,
                           input exp_t e);
        @(negedge clk);
        b_glitc = idx; b_addr = addr; b_datw = 32'h0; b_rd = 1'b1;
        e.req = cyc + 1;
        qb.push_back(e);
        @(negedge clk);
        b_rd = 1'b0;
    endtask

    task automatic wait_ack_a();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (a_ack) seen = 1'b1;
        end
        if (!seen) chk("a_ack_timeout", 64'(seen), 64'(1));
    endtask

    task automatic wait_ack_b();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (b_ack) seen = 1'b1;
        end
        if (!seen) chk("b_ack_timeout", 64'(seen), 64'(1));
    endtask

    initial begin
        rst = 1'b1;
        a_glitc = 2'd0; a_addr = 16'h0; a_datw = 32'h0; a_wr = 0; a_rd = 0;
        b_glitc = 2'd0; b_addr = 16'h0; b_datw = 32'h0; b_wr = 0; b_rd = 0;
        for (int i = 0; i < 4; i++) begin
            a_rb[i] = 8'h00;
            b_rb[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk("rst_gsel", 64'(a_gsel), 64'(4'hF));
        chk("rst_grdwr", 64'(a_grdwr), 64'(1));
        chk("rst_gad", 64'(a_gad), 64'(0));
        chk("rst_oe", 64'(a_oe), 64'(0));
        chk("rst_ack", 64'(a_ack), 64'(0));
        chk("rst_busy", 64'(a_busy), 64'(0));
        chk("rst_dat", 64'(a_dato), 64'(0));
        chk("rst_b_gsel", 64'(b_gsel), 64'(3'h7));
        rst = 1'b0;

        issue_a(0, 1, 0, 2'd1, 16'h0042, 32'hDEADBEEF,
                mk_w(4'b0010, 16'h0042, 32'hDEADBEEF));
        wait_ack_a();

        a_rb[0] = 8'h12; a_rb[1] = 8'h34; a_rb[2] = 8'h56; a_rb[3] = 8'h78;
        issue_a(0, 0, 1, 2'd0, 16'h0810, 32'h0,
                mk_r(4'b0001, 16'h0810, 32'h12345678, 2));
        wait_ack_a();

        issue_a(0, 1, 1, 2'd2, 16'h1234, 32'hCAFEF00D,
                mk_w(4'b0100, 16'h1234, 32'hCAFEF00D));
        repeat (2) @(negedge clk);
        a_glitc = 2'd3; a_rd = 1'b1;
        @(negedge clk);
        a_rd = 1'b0;
        wait_ack_a();
        repeat (10) @(negedge clk);

        issue_a(0, 1, 0, 2'd3, 16'hABCD, 32'h01020304,
                mk_w(4'b1000, 16'hABCD, 32'h01020304));
        wait_ack_a();
        a_rb[0] = 8'h9A; a_rb[1] = 8'hBC; a_rb[2] = 8'hDE; a_rb[3] = 8'hF0;
        issue_a(1, 0, 1, 2'd1, 16'h00FF, 32'h0,
                mk_r(4'b0010, 16'h00FF, 32'h9ABCDEF0, 2));
        wait_ack_a();

        issue_a(0, 1, 0, 2'd0, 16'h5555, 32'h11223344,
                mk_w(4'b0001, 16'h5555, 32'h11223344));
        repeat (5) @(posedge clk);
        #2;
        chk("mid_byte3", 64'(a_gad), 64'(8'h33));
        rst = 1'b1;
        #1;
        chk("mid_rst_gsel", 64'(a_gsel), 64'(4'hF));
        chk("mid_rst_oe", 64'(a_oe), 64'(0));
        chk("mid_rst_busy", 64'(a_busy), 64'(0));
        qa.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (12) @(negedge clk);

        a_rb[0] = 8'h01; a_rb[1] = 8'h02; a_rb[2] = 8'h03; a_rb[3] = 8'h04;
        issue_a(0, 0, 1, 2'd3, 16'h0001, 32'h0,
                mk_r(4'b1000, 16'h0001, 32'h01020304, 2));
        wait_ack_a();

        b_rb[0] = 8'h77; b_rb[1] = 8'h66; b_rb[2] = 8'h55; b_rb[3] = 8'h44;
        issue_b(2'd2, 16'h0100, mk_r(4'b0100, 16'h0100, 32'h77665544, 5));
        wait_ack_b();

        tmp = mk_r(4'b0000, 16'h0020, 32'h0000_0000, 5);
        tmp.selc = 0;
        issue_b(2'd3, 16'h0020, tmp);
        wait_ack_b();

        repeat (4) @(negedge clk);
        chk("a_queue_empty", 64'(qa.size()), 64'(0));
        chk("b_queue_empty", 64'(qb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
